// File: rtl/adc_emu_pkg.sv
// Shared defaults and state encoding for the dual-channel ADC emulator.
package adc_emu_pkg;

    localparam int DEF_CHANNEL_DATA_WIDTH = 18;
    localparam int DEF_ADC_DATA_WIDTH     = 2 * DEF_CHANNEL_DATA_WIDTH;

    // SPI mode 0: SCK idles low, master samples on the rising edge.
    localparam int SPI_MODE = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        SHIFT   = 2'd2
    } state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous 1-bit input with one-cycle
// rise/fall strobes taken from the synchronized signal.
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [2:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], d_i};
        end
    end

    assign rise_o = sync_q[1] & ~sync_q[2];
    assign fall_o = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/adc_dual_ch_emulator.sv
// Dual-channel 18-bit ADC emulator: CNV starts a timed conversion (BUSY),
// then the latched {ch1, ch2} frame is shifted out MSB first on SCK.
module adc_dual_ch_emulator
    import adc_emu_pkg::*;
#(
    parameter int CHANNEL_DATA_WIDTH = DEF_CHANNEL_DATA_WIDTH,
    parameter int ADC_DATA_WIDTH     = DEF_ADC_DATA_WIDTH,
    parameter int CONV_CYCLES        = 40,
    parameter int CONV_CNT_WIDTH     = 8,
    parameter int BIT_CNT_WIDTH      = 6,
    parameter int CONV_COUNT_WIDTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cnv,
    input  logic                          sck,
    input  logic [CHANNEL_DATA_WIDTH-1:0] ch1_in,
    input  logic [CHANNEL_DATA_WIDTH-1:0] ch2_in,
    output logic                          busy,
    output logic                          miso,
    output logic                          frame_sent,
    output logic                          overrun,
    output logic [CONV_COUNT_WIDTH-1:0]   frame_count
);

    localparam logic [CONV_CNT_WIDTH-1:0] CONV_LOAD = CONV_CNT_WIDTH'(CONV_CYCLES - 1);
    localparam logic [BIT_CNT_WIDTH-1:0]  LAST_BIT  = BIT_CNT_WIDTH'(ADC_DATA_WIDTH);

    state_e                        state_q, state_d;
    logic [CONV_CNT_WIDTH-1:0]     conv_cnt_q, conv_cnt_d;
    logic [BIT_CNT_WIDTH-1:0]      bit_cnt_q, bit_cnt_d;
    logic [ADC_DATA_WIDTH-1:0]     shift_q, shift_d;
    logic                          busy_q, busy_d;
    logic                          miso_q, miso_d;
    logic                          frame_sent_q, frame_sent_d;
    logic                          overrun_q, overrun_d;
    logic [CONV_COUNT_WIDTH-1:0]   count_q, count_d;
    logic                          start_conv;
    logic                          cnv_rise, cnv_fall_unused, sck_rise, sck_fall;

    sync_edge_detect u_cnv_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (cnv),
        .rise_o (cnv_rise),
        .fall_o (cnv_fall_unused)
    );

    sync_edge_detect u_sck_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (sck),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            conv_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            busy_q       <= 1'b0;
            miso_q       <= 1'b0;
            frame_sent_q <= 1'b0;
            overrun_q    <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            conv_cnt_q   <= conv_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            busy_q       <= busy_d;
            miso_q       <= miso_d;
            frame_sent_q <= frame_sent_d;
            overrun_q    <= overrun_d;
            count_q      <= count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        conv_cnt_d   = conv_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        busy_d       = busy_q;
        miso_d       = miso_q;
        frame_sent_d = 1'b0;
        overrun_d    = overrun_q;
        count_d      = count_q;
        start_conv   = 1'b0;

        unique case (state_q)
            IDLE: begin
                busy_d     = 1'b0;
                miso_d     = 1'b0;
                start_conv = cnv_rise;
            end
            CONVERT: begin
                if (cnv_rise) overrun_d = 1'b1;
                if (conv_cnt_q == '0) begin
                    busy_d    = 1'b0;
                    miso_d    = shift_q[ADC_DATA_WIDTH-1];
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end else begin
                    conv_cnt_d = conv_cnt_q - 1'b1;
                end
            end
            SHIFT: begin
                if (sck_fall) begin
                    shift_d = shift_q << 1;
                    miso_d  = shift_q[ADC_DATA_WIDTH-2];
                end
                if (sck_rise) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_d == LAST_BIT) begin
                        frame_sent_d = 1'b1;
                        count_d      = count_q + 1'b1;
                        miso_d       = 1'b0;
                        state_d      = IDLE;
                    end
                end
                // A CNV landing on the final rising edge is a clean back-to-back start.
                if (cnv_rise) begin
                    start_conv = 1'b1;
                    if (!frame_sent_d) overrun_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start_conv) begin
            shift_d    = {ch1_in, ch2_in};
            conv_cnt_d = CONV_LOAD;
            busy_d     = 1'b1;
            miso_d     = 1'b0;
            state_d    = CONVERT;
        end
    end

    assign busy        = busy_q;
    assign miso        = miso_q;
    assign frame_sent  = frame_sent_q;
    assign overrun     = overrun_q;
    assign frame_count = count_q;

endmodule
